// File: rtl/lane_proto_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lane_proto_pkg : frame layout shared by transmit_lane and receive_lane    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package lane_proto_pkg;

  localparam int         LANE_WIDTH    = 8;
  localparam int         PULSE_LEN_DEF = 16;
  localparam logic [7:0] SYNC_DEF      = 8'hA5;
  localparam int         SYNC_CYCLES   = 1;
  localparam int         CHECK_CYCLES  = 1;

  // Total lane cycles one frame occupies: SYNC, held data, inverse check.
  function automatic int frame_cycles(input int pulse_len);
    return SYNC_CYCLES + pulse_len + CHECK_CYCLES;
  endfunction

  function automatic logic [LANE_WIDTH-1:0] check_code(input logic [LANE_WIDTH-1:0] d);
    return ~d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rx_fifo : first-word-fall-through FIFO with wrap-bit pointers             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign data_out = r_mem[r_rd_ptr[AW-1:0]];

  // A pop frees the slot in the same cycle, so a full FIFO may still accept.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lane_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lane_receiver : frames, checks and queues bytes from the transmit lane    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lane_receiver
  import lane_proto_pkg::*;
#(
  parameter int               WIDTH     = LANE_WIDTH,
  parameter int               PULSE_LEN = PULSE_LEN_DEF,
  parameter logic [WIDTH-1:0] SYNC      = WIDTH'(SYNC_DEF),
  parameter int               DEPTH     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] receive_lane,
  input  logic             re,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             frame_err,
  output logic             overflow,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam int            CW       = $clog2(PULSE_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_LEN - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_cap;
  logic             r_bad;
  logic             r_overflow;
  logic [7:0]       r_err_count;

  logic             w_in_check;
  logic             w_good;
  logic             w_pop;
  logic             w_room;
  logic             w_push;

  assign w_in_check = (r_state == ST_CHECK);
  assign w_good     = w_in_check && !r_bad && (receive_lane == ~r_cap);
  assign w_pop      = re && !empty;
  assign w_room     = !full || w_pop;
  assign w_push     = w_good && w_room;

  assign frame_err  = w_in_check && !w_good;
  assign overflow   = r_overflow;
  assign err_count  = r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cap       <= '0;
      r_bad       <= 1'b0;
      r_overflow  <= 1'b0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (receive_lane == SYNC) begin
            r_state <= ST_DATA;
            r_cnt   <= '0;
            r_bad   <= 1'b0;
          end
        end
        ST_DATA: begin
          // SYNC is not special here, so a data byte equal to SYNC is legal.
          if (r_cnt == '0) begin
            r_cap <= receive_lane;
          end else if (receive_lane != r_cap) begin
            r_bad <= 1'b1;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_state <= ST_IDLE;
          if (w_good && !w_room) begin
            r_overflow <= 1'b1;
          end
          if (!w_good && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (r_cap),
    .pop       (w_pop),
    .data_out  (data_out),
    .empty     (empty),
    .full      (full)
  );

endmodule
`default_nettype wire

// File: doc/lane_receiver.md
Name: lane_receiver

Overview:
Receive end of the 8-bit parallel transmit lane driven by the team's FIFO-fed transmitter.
- Detects framed bytes on the lane and checks each for hold-stability and inverse-check.
- Pushes good bytes into an internal FIFO for a downstream reader.
- Pairs with the transmitter in loopback tops and benches (transmit_lane -> receive_lane).

Parameters:
WIDTH, 8, lane and data width in bits
PULSE_LEN, 16, cycles each data byte is held on the lane (>=2; the transmitter's pulse counter uses the same value)
SYNC, 8'hA5, frame start code
DEPTH, 8, receive FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
receive_lane  in  WIDTH  lane from the transmitter
re  in  1  read enable; pops the head entry when empty=0
data_out  out  WIDTH  FIFO head, first-word-fall-through
empty  out  1  FIFO holds no entries
full  out  1  FIFO holds DEPTH entries
frame_err  out  1  one-cycle pulse when a frame is rejected
overflow  out  1  sticky; set when a good frame is dropped because the FIFO is full
err_count  out  8  saturating count of rejected frames

Behaviour:
Frame on the lane: 1 cycle SYNC, then byte D held for PULSE_LEN cycles, then 1 cycle ~D. Frames may be back-to-back. The lane value between frames is don't-care, except that SYNC starts a frame.

Reset (rst=1 at an edge):
- State returns to IDLE; counter and capture register are cleared.
- FIFO pointers clear: empty=1, full=0, data_out=0.
- frame_err=0, overflow=0, err_count=0.
- Reset mid-frame abandons the frame with no push and no error.

State machine (IDLE, DATA, CHECK):
- IDLE: lane==SYNC -> DATA, cnt<=0, bad<=0. Otherwise stay.
- DATA, cnt==0: capture lane into cap.
- DATA, cnt>0: lane!=cap sets bad.
- DATA: cnt increments each cycle; after the cnt==PULSE_LEN-1 cycle -> CHECK. SYNC appearing inside DATA is treated as data, so D=8'hA5 is legal.
- CHECK: good = !bad && lane==~cap.
  - good and (!full or re&&!empty in the same cycle): push cap.
  - good and full without a same-cycle pop: drop the byte and set overflow.
  - not good: frame_err=1 for this cycle; err_count increments, saturating at 255.
  - In all cases -> IDLE. The next frame's SYNC may appear on the cycle after CHECK.

Latency:
- SYNC at cycle t: data cycles t+1..t+PULSE_LEN, check cycle t+PULSE_LEN+1.
- empty falls and data_out is valid from cycle t+PULSE_LEN+2.

FIFO:
- Pointers are clog2(DEPTH)+1 bits with wrap bit. empty when pointers are equal; full when indices are equal and wrap bits differ.
- re while empty is ignored.
- Push and pop in the same cycle: both happen and the count is unchanged.
- Pointers wrap modulo 2*DEPTH.
- data_out is combinational from mem[rd_idx], with no read latency.
- overflow clears only on rst.

Decomposition:
- Shared header/package lane_proto_pkg: SYNC, PULSE_LEN defaults and the frame-layout constants, so transmitter and receiver agree.
- Receiver state encodings (IDLE=0, DATA=1, CHECK=2) are local to the receiver.
- One sub-module: rx_fifo (WIDTH, DEPTH; push, push_data, pop, data_out, empty, full). The frame FSM stays in lane_receiver.

Test Plan:
1. Reset, then frames A5,03x16,FC / A5,04x16,FB / A5,05x16,FA back-to-back, no reads -> empty falls 18 cycles after the first SYNC; pops return 03,04,05; frame_err never asserts; then empty=1.
2. Frame with D=A5 (lane A5 x17, then 5A) -> one entry 8'hA5 pushed, no error.
3. Frame 07 with lane=06 on data cycle 9 -> frame_err pulses on the check cycle, err_count=1, FIFO unchanged. Frame 07 with check byte 07 instead of F8 -> err_count=2.
4. Fill 8 frames (10..17), no reads -> full=1. 9th frame 18 -> overflow=1, contents still 10..17. 10th frame 19 with re=1 on its check cycle -> 10 popped, 19 accepted, full stays 1.
5. rst asserted on data cycle 5 of a frame, lane continues the frame -> no push, no frame_err. The next clean frame 2A is received.
6. 256 bad frames -> err_count holds at 255.
